// File: rtl/tia_video_pkg.sv
// Shared constants and capture-FSM state encoding for the TIA video path.
package tia_video_pkg;

    localparam int FB_W_DEF      = 160;
    localparam int FB_H_DEF      = 240;
    localparam int AW_DEF        = 16;
    localparam int HBLANK_DEF    = 68;
    localparam int TOP_LINES_DEF = 40;
    localparam int PIX_W         = 7;

    typedef enum logic [1:0] {
        ST_WAIT_VSYNC = 2'd0,
        ST_SKIP       = 2'd1,
        ST_ACTIVE     = 2'd2,
        ST_DONE       = 2'd3
    } fb_state_e;

endpackage

// File: rtl/fb_dpram.sv
// Simple dual-port frame store: one write port, one registered read port (read-before-write).
module fb_dpram
    import tia_video_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = PIX_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [DW-1:0] rd_data_o
);

    logic [DW-1:0] mem_q [0:(1<<AW)-1];
    logic [DW-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Only the output register is reset; the array contents survive reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/tia_frame_buffer.sv
// Captures the TIA colour-clock pixel stream into a frame store and serves registered reads.
// state      | meaning
// WAIT_VSYNC | idle until vsync falls
// SKIP       | counting top border lines
// ACTIVE     | writing visible pixels of lines 0..FB_H-1
// DONE       | one-cycle frame_done, then back to WAIT_VSYNC
module tia_frame_buffer
    import tia_video_pkg::*;
#(
    parameter int HBLANK    = HBLANK_DEF,
    parameter int TOP_LINES = TOP_LINES_DEF,
    parameter int FB_W      = FB_W_DEF,
    parameter int FB_H      = FB_H_DEF,
    parameter int AW        = AW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pix_ce,
    input  logic [6:0]    pix_color,
    input  logic          tia_hsync,
    input  logic          tia_vsync,
    input  logic [AW-1:0] vga_addr,
    output logic [6:0]    vga_data,
    output logic          frame_done,
    output logic          capturing
);

    fb_state_e     state_q, state_d;
    logic          hs_q, vs_q;
    logic          hs_rise, vs_fall;
    logic [7:0]    hcount_q, hcount_d;
    logic [7:0]    skip_q, skip_d;
    logic [7:0]    line_q, line_d;
    logic [AW-1:0] base_q, base_d;
    logic          capturing_q, capturing_d;
    logic          frame_done_q, frame_done_d;
    logic          in_window;
    logic          wr_en;
    logic [AW-1:0] wr_addr;

    assign hs_rise = tia_hsync & ~hs_q;
    assign vs_fall = ~tia_vsync & vs_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_WAIT_VSYNC;
            hs_q         <= 1'b0;
            vs_q         <= 1'b0;
            hcount_q     <= '0;
            skip_q       <= '0;
            line_q       <= '0;
            base_q       <= '0;
            capturing_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hs_q         <= tia_hsync;
            vs_q         <= tia_vsync;
            hcount_q     <= hcount_d;
            skip_q       <= skip_d;
            line_q       <= line_d;
            base_q       <= base_d;
            capturing_q  <= capturing_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        skip_d   = skip_q;
        line_d   = line_q;
        base_d   = base_q;
        hcount_d = hcount_q;
        if (hs_rise) begin
            hcount_d = '0;
        end else if (pix_ce && hcount_q != 8'hFF) begin
            hcount_d = hcount_q + 8'd1;
        end
        // A falling vsync restarts the frame from any state, including mid-capture.
        if (vs_fall) begin
            state_d = ST_SKIP;
            skip_d  = '0;
        end else begin
            case (state_q)
                ST_WAIT_VSYNC: state_d = ST_WAIT_VSYNC;
                ST_SKIP: begin
                    if (hs_rise) begin
                        skip_d = skip_q + 8'd1;
                        if (skip_q == 8'(TOP_LINES - 1)) begin
                            state_d = ST_ACTIVE;
                            line_d  = '0;
                            base_d  = '0;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (hs_rise) begin
                        if (line_q == 8'(FB_H - 1)) begin
                            state_d = ST_DONE;
                        end else begin
                            line_d = line_q + 8'd1;
                            base_d = base_q + AW'(FB_W);
                        end
                    end
                end
                ST_DONE:  state_d = ST_WAIT_VSYNC;
                default:  state_d = ST_WAIT_VSYNC;
            endcase
        end
    end

    always_comb begin
        in_window    = (hcount_q >= 8'(HBLANK)) && (hcount_q < 8'(HBLANK + FB_W));
        wr_en        = (state_q == ST_ACTIVE) && pix_ce && in_window && !hs_rise && !reset;
        wr_addr      = base_q + AW'(hcount_q - 8'(HBLANK));
        capturing_d  = (state_d == ST_ACTIVE);
        frame_done_d = (state_d == ST_DONE);
    end

    fb_dpram #(
        .AW (AW),
        .DW (7)
    ) u_fb_dpram (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (pix_color),
        .rd_addr_i (vga_addr),
        .rd_data_o (vga_data)
    );

    assign capturing  = capturing_q;
    assign frame_done = frame_done_q;

endmodule
